// File: rtl/pc_gen_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen_unit
// Description : Fetch-stage program-counter generator. Holds the fetch PC and
//               picks the next PC from trap entry, EX redirect, trap return,
//               stall hold, optional return-address-stack prediction, or the
//               sequential increment. Captures the exception PC and flags
//               misaligned redirect targets.
// Revision    : 1.0 - initial release
//
// Optional feature macro: PC_RAS_EN (circular return-address stack)
//
// Ports:
//   clk             in   rising-edge clock
//   reset           in   asynchronous active-low reset
//   pc_write        in   1 = advance, 0 = stall (hold PC)
//   redirect_valid  in   EX resolved taken branch/jump
//   redirect_target in   redirect destination
//   trap_valid      in   exception/interrupt entry
//   trap_pc         in   PC of the trapping instruction
//   xret_valid      in   return from trap
//   ras_push        in   IF predicted call
//   ras_pop         in   IF predicted return
//   pc_out          out  current fetch PC (registered)
//   pc_plus_inc     out  pc_out + INC (combinational)
//   epc_out         out  exception PC register
//   misalign_fault  out  one-cycle pulse after a misaligned redirect
//   ras_empty       out  RAS holds no entries (tied 1 without PC_RAS_EN)
// ============================================================================
module pc_gen_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              INC          = 4,
  parameter int              ALIGN_BITS   = 2,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_write,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            xret_valid,
  input  logic            ras_push,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus_inc,
  output logic [XLEN-1:0] epc_out,
  output logic            misalign_fault,
  output logic            ras_empty
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] epc_d;
  logic            mis_q;
  logic            mis_d;
  logic            misaligned_target;

  assign misaligned_target = |redirect_target[ALIGN_BITS-1:0];
  assign pc_plus_inc       = pc_q + XLEN'(INC);

`ifdef PC_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;     // next free slot; top lives at ras_ptr-1
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W:0]   ras_cnt;
  logic [XLEN-1:0]  ras_top;
  logic             ras_ok;      // cycle where push/pop are honoured
  logic             ras_clear;   // trap or misaligned redirect empties stack
  logic             do_push;
  logic             do_pop;

  assign top_idx   = ras_ptr - PTR_W'(1);
  assign ras_top   = ras_mem[top_idx];
  assign ras_empty = (ras_cnt == '0);
  assign ras_ok    = pc_write & ~trap_valid & ~redirect_valid & ~xret_valid;
  assign ras_clear = trap_valid | (redirect_valid & misaligned_target);
  assign do_push   = ras_ok & ras_push;
  assign do_pop    = ras_ok & ras_pop & ~ras_empty;

  // Pointer/count bookkeeping. Clearing only zeroes the count; stale entries
  // are unreachable because pops are bounded by the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else if (ras_clear) begin
      ras_cnt <= '0;
    end else if (do_push && do_pop) begin
      // top replaced in place; depth unchanged
      ras_ptr <= ras_ptr;
    end else if (do_push) begin
      ras_ptr <= ras_ptr + PTR_W'(1);
      // when full, the write lands on the oldest entry and count saturates
      if (ras_cnt != (PTR_W+1)'(RAS_DEPTH)) begin
        ras_cnt <= ras_cnt + (PTR_W+1)'(1);
      end
    end else if (do_pop) begin
      ras_ptr <= top_idx;
      ras_cnt <= ras_cnt - (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: contents are only read when the count says valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      ras_mem[do_pop ? top_idx : ras_ptr] <= pc_plus_inc;
    end
  end
`else
  logic unused_ras_inputs;
  assign unused_ras_inputs = ras_push ^ ras_pop;
  assign ras_empty         = 1'b1;
`endif

  // Next-PC priority: trap > misaligned redirect > redirect > xret > stall
  // > RAS pop > sequential. Flush sources ignore pc_write.
  always_comb begin
    pc_d  = pc_plus_inc;
    epc_d = epc_q;
    mis_d = 1'b0;
    if (trap_valid) begin
      pc_d  = TRAP_VECTOR;
      epc_d = trap_pc;
    end else if (redirect_valid && misaligned_target) begin
      pc_d  = TRAP_VECTOR;
      epc_d = redirect_target;
      mis_d = 1'b1;
    end else if (redirect_valid) begin
      pc_d = redirect_target;
    end else if (xret_valid) begin
      pc_d = epc_q;
    end else if (!pc_write) begin
      pc_d = pc_q;
    end else begin
`ifdef PC_RAS_EN
      if (ras_pop && !ras_empty) begin
        pc_d = ras_top;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_VECTOR;
      epc_q <= '0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
      mis_q <= mis_d;
    end
  end

  assign pc_out         = pc_q;
  assign epc_out        = epc_q;
  assign misalign_fault = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_gen_unit
// Description : Self-checking bench for pc_gen_unit: directed vector table,
//               hand-written reset/RAS sequences and randomized stimulus
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen_unit;

  localparam int RAS_DEPTH = 4;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        pc_write;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        xret_valid;
  logic        ras_push;
  logic        ras_pop;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_inc;
  logic [31:0] epc_out;
  logic        misalign_fault;
  logic        ras_empty;

  pc_gen_unit #(
    .XLEN(32), .RESET_VECTOR(32'h0), .TRAP_VECTOR(TRAP_VEC),
    .INC(4), .ALIGN_BITS(2), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .pc_write(pc_write),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .xret_valid(xret_valid),
    .ras_push(ras_push), .ras_pop(ras_pop),
    .pc_out(pc_out), .pc_plus_inc(pc_plus_inc), .epc_out(epc_out),
    .misalign_fault(misalign_fault), .ras_empty(ras_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          pw;
    bit          redir;
    logic [31:0] tgt;
    bit          trap;
    logic [31:0] tpc;
    bit          xret;
    bit          push;
    bit          pop;
    logic [31:0] e_pc;
    logic [31:0] e_epc;
    bit          e_mis;
    bit          e_emp;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic [31:0] m_ras[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit pw, bit redir, logic [31:0] tgt, bit trap,
                              logic [31:0] tpc, bit xret, bit push, bit pop,
                              logic [31:0] e_pc, logic [31:0] e_epc, bit e_mis, bit e_emp);
    vec_t v;
    v.pw = pw; v.redir = redir; v.tgt = tgt; v.trap = trap; v.tpc = tpc;
    v.xret = xret; v.push = push; v.pop = pop;
    v.e_pc = e_pc; v.e_epc = e_epc; v.e_mis = e_mis; v.e_emp = e_emp;
    return v;
  endfunction

  // Drive one cycle of inputs, clock it, then compare #1 after the edge.
  task automatic apply(input vec_t v, input string tag);
    pc_write        = v.pw;
    redirect_valid  = v.redir;
    redirect_target = v.tgt;
    trap_valid      = v.trap;
    trap_pc         = v.tpc;
    xret_valid      = v.xret;
    ras_push        = v.push;
    ras_pop         = v.pop;
    @(posedge clk);
    #1;
    chk({tag, " pc"},    pc_out,                v.e_pc);
    chk({tag, " epc"},   epc_out,               v.e_epc);
    chk({tag, " mis"},   {31'b0, misalign_fault}, {31'b0, v.e_mis});
    chk({tag, " plus"},  pc_plus_inc,           v.e_pc + 32'd4);
    chk({tag, " empty"}, {31'b0, ras_empty},    {31'b0, v.e_emp});
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_pc  = 32'h0;
    m_epc = 32'h0;
    m_ras.delete();
  endtask

  // Reference model: the priority rules with plain arithmetic and a queue
  // standing in for the return-address stack.
  task automatic model_step(inout vec_t v);
    logic [31:0] seq;
    seq     = m_pc + 32'd4;
    v.e_mis = 1'b0;
    if (v.trap) begin
      m_pc = TRAP_VEC; m_epc = v.tpc; m_ras.delete();
    end else if (v.redir && (v.tgt % 4) != 0) begin
      m_pc = TRAP_VEC; m_epc = v.tgt; v.e_mis = 1'b1; m_ras.delete();
    end else if (v.redir) begin
      m_pc = v.tgt;
    end else if (v.xret) begin
      m_pc = m_epc;
    end else if (v.pw) begin
`ifdef PC_RAS_EN
      if (v.pop && m_ras.size() > 0) begin
        m_pc = m_ras.pop_back();
        if (v.push) m_ras.push_back(seq);
      end else begin
        if (v.push) begin
          m_ras.push_back(seq);
          if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
        end
        m_pc = seq;
      end
`else
      m_pc = seq;
`endif
    end
    v.e_pc  = m_pc;
    v.e_epc = m_epc;
`ifdef PC_RAS_EN
    v.e_emp = (m_ras.size() == 0);
`else
    v.e_emp = 1'b1;
`endif
  endtask

  vec_t tbl[17];

  initial begin
    //            pw redir tgt            trap tpc     xret push pop  e_pc           e_epc     mis emp
    tbl[0]  = mk(1, 0, 32'h0,         0, 32'h0,  0, 0, 0, 32'h4,         32'h0,  0, 1);
    tbl[1]  = mk(1, 0, 32'h0,         0, 32'h0,  0, 0, 0, 32'h8,         32'h0,  0, 1);
    tbl[2]  = mk(1, 0, 32'h0,         0, 32'h0,  0, 0, 0, 32'hC,         32'h0,  0, 1);
    tbl[3]  = mk(1, 1, 32'h20,        0, 32'h0,  0, 0, 0, 32'h20,        32'h0,  0, 1);
    tbl[4]  = mk(0, 0, 32'h0,         0, 32'h0,  0, 0, 0, 32'h20,        32'h0,  0, 1);
    tbl[5]  = mk(0, 0, 32'h0,         0, 32'h0,  0, 0, 0, 32'h20,        32'h0,  0, 1);
    tbl[6]  = mk(0, 1, 32'h80,        0, 32'h0,  0, 0, 0, 32'h80,        32'h0,  0, 1);
    tbl[7]  = mk(1, 1, 32'h200,       1, 32'h44, 0, 0, 0, 32'h100,       32'h44, 0, 1);
    tbl[8]  = mk(1, 0, 32'h0,         0, 32'h0,  0, 0, 0, 32'h104,       32'h44, 0, 1);
    tbl[9]  = mk(0, 0, 32'h0,         0, 32'h0,  1, 0, 0, 32'h44,        32'h44, 0, 1);
    tbl[10] = mk(1, 1, 32'h82,        0, 32'h0,  0, 0, 0, 32'h100,       32'h82, 1, 1);
    tbl[11] = mk(1, 0, 32'h0,         0, 32'h0,  0, 0, 0, 32'h104,       32'h82, 0, 1);
    tbl[12] = mk(1, 0, 32'h0,         0, 32'h0,  1, 0, 0, 32'h82,        32'h82, 0, 1);
    tbl[13] = mk(1, 1, 32'hFFFF_FFFC, 0, 32'h0,  0, 0, 0, 32'hFFFF_FFFC, 32'h82, 0, 1);
    tbl[14] = mk(1, 0, 32'h0,         0, 32'h0,  0, 0, 0, 32'h0,         32'h82, 0, 1);
    tbl[15] = mk(1, 0, 32'h0,         1, 32'h10, 1, 0, 0, 32'h100,       32'h10, 0, 1);
    tbl[16] = mk(0, 0, 32'h0,         0, 32'h0,  1, 0, 0, 32'h10,        32'h10, 0, 1);

    reset = 1'b0; pc_write = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    trap_valid = 1'b0; trap_pc = '0; xret_valid = 1'b0; ras_push = 1'b0; ras_pop = 1'b0;
    m_pc = '0; m_epc = '0;

    #12;
    chk("reset pc",    pc_out,  32'h0);
    chk("reset epc",   epc_out, 32'h0);
    chk("reset mis",   {31'b0, misalign_fault}, 32'h0);
    chk("reset empty", {31'b0, ras_empty}, 32'h1);
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // asynchronous reset mid-cycle, before any clock edge
    apply(mk(1, 1, 32'h300, 0, 32'h0, 0, 0, 0, 32'h300, 32'h10, 0, 1), "pre_async");
    #2;
    reset = 1'b0;
    #1;
    chk("async pc",  pc_out,  32'h0);
    chk("async epc", epc_out, 32'h0);
    @(posedge clk);
    #1;
    chk("async hold pc", pc_out, 32'h0);
    reset = 1'b1;

    // return-address stack sequence: pushes at 0x10..0x50, then five pops
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      logic [31:0] base;
      base = 32'h10 * k;
`ifdef PC_RAS_EN
      apply(mk(1, 1, base, 0, 0, 0, 0, 0, base, 32'h0, 0, (k == 1)), "ras_redir");
      apply(mk(1, 0, 0, 0, 0, 0, 1, 0, base + 32'h4, 32'h0, 0, 0), "ras_push");
`else
      apply(mk(1, 1, base, 0, 0, 0, 0, 0, base, 32'h0, 0, 1), "ras_redir");
      apply(mk(1, 0, 0, 0, 0, 0, 1, 0, base + 32'h4, 32'h0, 0, 1), "ras_push");
`endif
    end
    for (int j = 0; j < 5; j++) begin
      logic [31:0] e;
      bit          emp;
`ifdef PC_RAS_EN
      e   = (j < 4) ? (32'h54 - 32'h10 * j) : 32'h28;
      emp = (j >= 3);
`else
      e   = 32'h58 + 32'h4 * j;
      emp = 1'b1;
`endif
      apply(mk(1, 0, 0, 0, 0, 0, 0, 1, e, 32'h0, 0, emp), $sformatf("ras_pop%0d", j));
    end

    // randomized stimulus against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      vec_t v;
      v.trap  = ($urandom_range(0, 19) == 0);
      v.redir = ($urandom_range(0, 6) == 0);
      v.tgt   = $urandom & 32'h0000_03FC;
      if ($urandom_range(0, 3) == 0) v.tgt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) v.tgt = 32'hFFFF_FFF8;
      v.tpc   = $urandom;
      v.xret  = ($urandom_range(0, 15) == 0);
      v.pw    = ($urandom_range(0, 4) != 0);
      v.push  = ($urandom_range(0, 2) == 0);
      v.pop   = ($urandom_range(0, 2) == 0);
      model_step(v);
      apply(v, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Parametrised fetch-stage program-counter generator; successor to the fixed 32-bit PC register plus PC+4 adder.
- Holds the architectural fetch PC and selects the next PC each cycle from these sources: trap entry, EX-stage branch/jump redirect, trap return, stall hold, optional return-address-stack (RAS) prediction, or sequential increment.
- Captures the exception PC (EPC) and flags misaligned redirect targets.
- Sits between the IF/ID pipeline register and the instruction-memory address port.

Parameters:
- XLEN, 32: PC, EPC and target width.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100: PC value loaded on trap entry or misaligned redirect.
- INC, 4: sequential increment in bytes.
- ALIGN_BITS, 2: count of low target bits that must be zero.
- RAS_DEPTH, 4: RAS entries (power of two, ≥2); used only with PC_RAS_EN.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- pc_write  in  1  1 = advance, 0 = stall (hold PC)
- redirect_valid  in  1  EX resolved taken branch/jump
- redirect_target  in  XLEN  redirect destination
- trap_valid  in  1  exception/interrupt entry
- trap_pc  in  XLEN  PC of the trapping instruction
- xret_valid  in  1  return from trap
- ras_push  in  1  IF predicted call
- ras_pop  in  1  IF predicted return
- pc_out  out  XLEN  current fetch PC (registered)
- pc_plus_inc  out  XLEN  pc_out + INC (combinational)
- epc_out  out  XLEN  exception PC register
- misalign_fault  out  1  one-cycle pulse (registered)
- ras_empty  out  1  RAS holds no entries

Behaviour:
- reset low, asynchronously and unconditionally (pc_write does not gate it):
  - pc_out = RESET_VECTOR, epc_out = 0, misalign_fault = 0.
  - RAS pointer = 0, RAS count = 0, ras_empty = 1.
- Next-PC selection is evaluated at every rising edge, highest priority first:
  1. trap_valid: pc <= TRAP_VECTOR; epc <= trap_pc; RAS count <= 0.
  2. redirect_valid with redirect_target[ALIGN_BITS-1:0] != 0: pc <= TRAP_VECTOR; epc <= redirect_target; misalign_fault <= 1; RAS count <= 0.
  3. redirect_valid, aligned target: pc <= redirect_target; RAS unchanged.
  4. xret_valid: pc <= epc_out.
  5. pc_write = 0: pc holds; ras_push and ras_pop are ignored.
  6. ras_pop with RAS non-empty (PC_RAS_EN only): pc <= RAS top.
  7. Otherwise: pc <= pc_out + INC.
- Cases 1–4 take effect even when pc_write = 0. A flush overrides a load-use stall.
- misalign_fault is high for exactly the cycle after case 2 and is 0 in all other cycles.
- All additions are modulo 2^XLEN. pc = 2^XLEN − INC wraps to 0 with no flag.
- pc_out is the only fetch address. Latency from any select input to pc_out is one cycle.
- epc_out changes only in cases 1 and 2.
- trap_valid and redirect_valid together: trap wins; the redirect is dropped.

Optional Feature:
- Macro: PC_RAS_EN.
- Defined: circular RAS of RAS_DEPTH × XLEN entries. Pushes and pops act only in case 6/7 cycles (pc_write = 1, no higher-priority event).
  - Push stores pc_out + INC. On a full RAS, the push overwrites the oldest entry and count saturates at RAS_DEPTH.
  - Pop on an empty RAS is ignored; next PC is sequential.
  - Push and pop in the same cycle: next pc = current top, then top is replaced by pc_out + INC; count unchanged.
  - ras_empty = (count == 0).
- Undefined: no RAS storage; ras_push and ras_pop are ignored; ras_empty is tied to 1; case 6 does not exist.

Test Plan:
- Reset and run: release reset, pc_write = 1 for 3 cycles -> pc_out goes 0x0, 0x4, 0x8, 0xC. Assert reset mid-run -> pc_out = 0x0 immediately, without waiting for a clock edge.
- Stall vs flush: pc = 0x20, pc_write = 0 for 2 cycles -> pc_out holds 0x20. Then pc_write = 0 with redirect_valid and target 0x80 -> pc_out = 0x80 next cycle.
- Trap and return: trap_valid with trap_pc = 0x44 and redirect_valid in the same cycle -> pc_out = 0x100, epc_out = 0x44. Later xret_valid -> pc_out = 0x44.
- Misaligned redirect: redirect_target = 0x82 -> pc_out = 0x100, epc_out = 0x82, misalign_fault = 1 for one cycle, then 0.
- Wrap: XLEN = 32, pc = 0xFFFF_FFFC -> next pc_out = 0x0.
- RAS (PC_RAS_EN defined): push at pc 0x10, 0x20, 0x30, 0x40, 0x50 with RAS_DEPTH = 4, then four pops -> pc_out sequence 0x54, 0x44, 0x34, 0x24. A fifth pop -> sequential increment, with ras_empty = 1.
